// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a little-endian byte stream into
// 32-bit words, writes them to consecutive addresses, then releases the CPU.
module imem_loader #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int          NUM_WORDS  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [15:0] word_count,
  output logic        busy,
  output logic        cpu_run,
  output logic        err,
  output logic [2:0]  dbg_state
);

  // Handshake: a byte (with its in_last flag) transfers on a rising edge where
  // in_valid && in_ready; in_valid may drop between bytes, in_ready never
  // depends on in_valid.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam logic [15:0] NUM_WORDS_W = 16'(NUM_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [15:0] wc_q, wc_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept;
  logic        full;
  logic [31:0] merged;

  assign in_ready = (state_q == IDLE) || (state_q == COLLECT);
  assign accept   = in_valid && in_ready;
  assign full     = (wc_q == NUM_WORDS_W);
  assign merged   = word_q | ({24'h0, in_data} << {idx_q, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      word_q  <= 32'h0;
      wc_q    <= 16'h0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= START_ADDR;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      wc_q    <= wc_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    wc_d    = wc_q;
    last_d  = last_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          // A byte that would start a word past capacity is refused outright,
          // so no write can ever land beyond the last word.
          if (idx_q == 2'd0 && full) begin
            state_d = ERROR;
          end else begin
            word_d = merged;
            idx_d  = idx_q + 2'd1;
            last_d = in_last;
            if (idx_q == 2'd3 || in_last) begin
              state_d = WRITE;
              we_d    = 1'b1;
              addr_d  = START_ADDR + {14'h0, wc_q, 2'b00};
              wdata_d = merged;
            end else begin
              state_d = COLLECT;
            end
          end
        end
      end
      WRITE: begin
        wc_d    = wc_q + 16'd1;
        word_d  = 32'h0;
        idx_d   = 2'd0;
        state_d = last_q ? DONE : COLLECT;
      end
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = wc_q;
  assign busy       = (state_q == COLLECT) || (state_q == WRITE);
  assign cpu_run    = (state_q == DONE);
  assign err        = (state_q == ERROR);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default instance (START_ADDR=0, 256 words)
// and a small instance (START_ADDR=0x100, 2 words) share the input stream.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        sel = 1'b0;

  logic        rdy0, we0, busy0, run0, err0;
  logic [31:0] addr0, wdata0;
  logic [15:0] wc0;
  logic [2:0]  st0;
  logic        rdy1, we1, busy1, run1, err1;
  logic [31:0] addr1, wdata1;
  logic [15:0] wc1;
  logic [2:0]  st1;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  imem_loader u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
    .word_count(wc0), .busy(busy0), .cpu_run(run0), .err(err0), .dbg_state(st0)
  );

  imem_loader #(.START_ADDR(32'h0000_0100), .NUM_WORDS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .word_count(wc1), .busy(busy1), .cpu_run(run1), .err(err1), .dbg_state(st1)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Driver: called at edge+1; returns at edge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
    int budget;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    budget   = 0;
    while (!(sel ? rdy1 : rdy0) && budget < 50) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 50) check("accept_timeout", 32'(budget), 32'd0);
    else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  // Scoreboard: every mem_we pulse on the watched instance must match the queue
  always @(negedge clk) begin
    if (rst_n && (sel ? we1 : we0)) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_we", {31'h0, (sel ? we1 : we0)}, 32'd0);
      end else begin
        check("wr_addr", sel ? addr1 : addr0, exp_addr_q.pop_front());
        check("wr_data", sel ? wdata1 : wdata0, exp_data_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", {31'h0, we0}, 32'd0);
    check("rst_addr0", addr0, 32'h0);
    check("rst_addr1", addr1, 32'h100);
    check("rst_wdata", wdata0, 32'h0);
    check("rst_wc", {16'h0, wc0}, 32'd0);
    check("rst_flags", {27'h0, busy0, run0, err0, 2'b00}, 32'h0);
    check("rst_state", {29'h0, st0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", {31'h0, rdy0}, 32'd1);

    // Single full word
    expect_write(32'h0, 32'h0010_0513);
    send_byte(8'h13, 1'b0, 0);
    check("t1_busy", {31'h0, busy0}, 32'd1);
    send_byte(8'h05, 1'b0, 0);
    send_byte(8'h10, 1'b0, 0);
    send_byte(8'h00, 1'b1, 0);
    check("t1_we_pulse", {31'h0, we0}, 32'd1);
    check("t1_ready_low", {31'h0, rdy0}, 32'd0);
    check("t1_wc_before", {16'h0, wc0}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_we_off", {31'h0, we0}, 32'd0);
    check("t1_wc", {16'h0, wc0}, 32'd1);
    check("t1_run", {31'h0, run0}, 32'd1);
    check("t1_ready", {31'h0, rdy0}, 32'd0);
    check("t1_busy_end", {31'h0, busy0}, 32'd0);
    check("t1_pending", 32'(exp_addr_q.size()), 32'd0);

    // Three words with random gaps
    do_reset();
    expect_write(32'h0, 32'h0302_0100);
    expect_write(32'h4, 32'h0706_0504);
    expect_write(32'h8, 32'h0B0A_0908);
    for (int i = 0; i < 12; i++) begin
      send_byte(8'(i), (i == 11), $urandom_range(0, 3));
      if (i % 4 == 3) begin
        check("t2_write_ready_low", {31'h0, rdy0}, 32'd0);
        check("t2_write_we", {31'h0, we0}, 32'd1);
      end
    end
    @(posedge clk);
    #1;
    check("t2_wc", {16'h0, wc0}, 32'd3);
    check("t2_run", {31'h0, run0}, 32'd1);
    check("t2_pending", 32'(exp_addr_q.size()), 32'd0);

    // Partial last word pads with zeros
    do_reset();
    expect_write(32'h0, 32'hADAC_ABAA);
    expect_write(32'h4, 32'h0000_AFAE);
    for (int i = 0; i < 6; i++) send_byte(8'hAA + 8'(i), (i == 5), 0);
    @(posedge clk);
    #1;
    check("t3_run", {31'h0, run0}, 32'd1);
    check("t3_err", {31'h0, err0}, 32'd0);
    check("t3_wc", {16'h0, wc0}, 32'd2);
    check("t3_pending", 32'(exp_addr_q.size()), 32'd0);

    // Overflow on the 2-word instance
    sel = 1'b1;
    do_reset();
    expect_write(32'h100, 32'h0403_0201);
    expect_write(32'h104, 32'h0807_0605);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 1'b0, 0);
    @(posedge clk);
    #1;
    check("t4_wc_full", {16'h0, wc1}, 32'd2);
    check("t4_err_before", {31'h0, err1}, 32'd0);
    send_byte(8'h09, 1'b0, 0);
    check("t4_err", {31'h0, err1}, 32'd1);
    check("t4_run", {31'h0, run1}, 32'd0);
    check("t4_ready", {31'h0, rdy1}, 32'd0);
    check("t4_busy", {31'h0, busy1}, 32'd0);
    check("t4_state", {29'h0, st1}, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    check("t4_wc_final", {16'h0, wc1}, 32'd2);
    check("t4_pending", 32'(exp_addr_q.size()), 32'd0);
    sel = 1'b0;

    // Reset mid-word discards the partial word
    do_reset();
    send_byte(8'hEE, 1'b0, 0);
    send_byte(8'hFF, 1'b0, 0);
    check("t5_busy_mid", {31'h0, busy0}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_async_state", {29'h0, st0}, 32'd0);
    check("t5_async_busy", {31'h0, busy0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_write(32'h0, 32'h0403_0201);
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), (i == 3), 0);
    @(posedge clk);
    #1;
    check("t5_wc", {16'h0, wc0}, 32'd1);
    check("t5_run", {31'h0, run0}, 32'd1);
    check("t5_pending", 32'(exp_addr_q.size()), 32'd0);

    // DONE ignores further traffic
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("t6_flags", {27'h0, rdy0, we0, busy0, run0, err0}, 32'b00010);
      check("t6_wc", {16'h0, wc0}, 32'd1);
      check("t6_addr", addr0, 32'h0);
      check("t6_state", {29'h0, st0}, 32'd3);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t6_pending", 32'(exp_addr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
